// File: rtl/gb_joypad_pkg.sv
// Shared constants and types for the Game Boy joypad (P1 register) reader.
package gb_joypad_pkg;

   localparam logic [15:0] P1_ADDR  = 16'hFF00;
   localparam logic [7:0]  P1_RESET = 8'hCF;

   typedef enum logic [2:0] {
      RIGHT  = 3'd0,
      LEFT   = 3'd1,
      UP     = 3'd2,
      DOWN   = 3'd3,
      A      = 3'd4,
      B      = 3'd5,
      SELECT = 3'd6,
      START  = 3'd7
   } joy_btn_t;

   typedef enum logic [0:0] {
      DEB_STABLE  = 1'b0,
      DEB_PENDING = 1'b1
   } deb_state_t;

endpackage

// File: rtl/gb_debounce.sv
// One button: a reset-to-released synchroniser chain followed by a
// counter-based debouncer; the stable output only follows a persistent change.
module gb_debounce
   import gb_joypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16384,
   parameter int SYNC_STAGES     = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw_n,
   output logic o_stable_n
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   deb_state_t             r_state;
   deb_state_t             w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nxt;
   logic                   r_stable;
   logic                   w_stable_nxt;
   logic                   w_sync;

   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign o_stable_n = r_stable;

   // Synchroniser chain for the asynchronous pin.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {SYNC_STAGES{1'b1}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw_n};
      end
   end

   // Debounce state, counter and stable value registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= DEB_STABLE;
         r_cnt    <= CW'(0);
         r_stable <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_stable <= w_stable_nxt;
      end
   end

   // Next-state logic: any return to the stable level restarts the count.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_stable_nxt = r_stable;
      case (r_state)
         DEB_STABLE: begin
            if (w_sync != r_stable) begin
               w_state_nxt = DEB_PENDING;
               w_cnt_nxt   = CW'(1);
            end else begin
               w_state_nxt = DEB_STABLE;
               w_cnt_nxt   = CW'(0);
            end
         end
         DEB_PENDING: begin
            if (w_sync == r_stable) begin
               w_state_nxt = DEB_STABLE;
               w_cnt_nxt   = CW'(0);
            end else if (r_cnt == CNT_MAX) begin
               w_state_nxt  = DEB_STABLE;
               w_cnt_nxt    = CW'(0);
               w_stable_nxt = w_sync;
            end else begin
               w_state_nxt = DEB_PENDING;
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = DEB_STABLE;
            w_cnt_nxt   = CW'(0);
         end
      endcase
   end

endmodule

// File: rtl/gb_joypad_ctrl.sv
// P1 (0xFF00) joypad register: debounced buttons, P14/P15 row select,
// registered read data and a falling-edge joypad interrupt pulse.
module gb_joypad_ctrl
   import gb_joypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16384,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       cpu_clk,
   input  logic       rst,
   input  logic       joypad_up,
   input  logic       joypad_down,
   input  logic       joypad_left,
   input  logic       joypad_right,
   input  logic       joypad_a,
   input  logic       joypad_b,
   input  logic       joypad_select,
   input  logic       joypad_start,
   input  logic       p1_sel,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq_joypad
);

   logic [7:0] w_raw;
   logic [7:0] w_stable;
   logic [1:0] r_sel;
   logic [3:0] w_nibble;
   logic [3:0] r_nibble_q;
   logic [7:0] r_rdata;
   logic       r_irq;
   logic       w_wr_hit;
   logic       w_rd_hit;
   logic       w_unused_wdata;

   assign w_raw[RIGHT]  = joypad_right;
   assign w_raw[LEFT]   = joypad_left;
   assign w_raw[UP]     = joypad_up;
   assign w_raw[DOWN]   = joypad_down;
   assign w_raw[A]      = joypad_a;
   assign w_raw[B]      = joypad_b;
   assign w_raw[SELECT] = joypad_select;
   assign w_raw[START]  = joypad_start;

   for (genvar g = 0; g < 8; g++) begin : g_btn
      gb_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_deb (
         .i_clk     (cpu_clk),
         .i_rst     (rst),
         .i_raw_n   (w_raw[g]),
         .o_stable_n(w_stable[g])
      );
   end

   assign w_wr_hit       = p1_sel & wr_en;
   assign w_rd_hit       = p1_sel & rd_en;
   assign w_unused_wdata = ^{wdata[7:6], wdata[3:0]};

   // Directions occupy stable[3:0], actions stable[7:4]; a 0 select bit exposes its row.
   assign w_nibble = (r_sel[0] ? 4'hF : w_stable[3:0]) &
                     (r_sel[1] ? 4'hF : w_stable[7:4]);

   assign rdata      = r_rdata;
   assign irq_joypad = r_irq;

   // Row-select register {P15,P14}.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         r_sel <= 2'b00;
      end else if (w_wr_hit) begin
         r_sel <= wdata[5:4];
      end else begin
         r_sel <= r_sel;
      end
   end

   // Read data captures the select bits as they were before a same-cycle write.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         r_rdata <= 8'hFF;
      end else if (w_rd_hit) begin
         r_rdata <= {2'b11, r_sel, w_nibble};
      end else begin
         r_rdata <= r_rdata;
      end
   end

   // Interrupt on any 1->0 nibble transition, including one exposed by a select write.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         r_nibble_q <= 4'hF;
         r_irq      <= 1'b0;
      end else begin
         r_nibble_q <= w_nibble;
         r_irq      <= |(r_nibble_q & ~w_nibble);
      end
   end

endmodule
